// File: rtl/row_checker.sv
// Tetris line-clear engine: drops every full row of a 20x10 board and compacts survivors toward row 0.
// Optional `ROWCHECK_COUNT_EN adds a rows_cleared output with the number of rows removed.
module row_checker (
  input  logic         Clk,
  input  logic         Reset,
  input  logic [199:0] game_board,
  output logic [199:0] new_board,
`ifdef ROWCHECK_COUNT_EN
  output logic [4:0]   rows_cleared,
`endif
  output logic         done
);

  typedef enum logic [1:0] {LOAD, SCAN, DONE} state_t;

  localparam logic [9:0] FULL_ROW = 10'h3FF;

  state_t         state_q, state_d;
  logic [199:0]   work_q, work_d;
  logic [199:0]   buf_q, buf_d;
  logic [199:0]   newBoard_q, newBoard_d;
  logic [4:0]     r_q, r_d;
  logic [4:0]     w_q, w_d;
  logic           done_q, done_d;
  logic [9:0]     rowVal;
`ifdef ROWCHECK_COUNT_EN
  logic [4:0]     count_q, count_d;
  logic [4:0]     rowsCleared_q, rowsCleared_d;
`endif

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q       <= LOAD;
      work_q        <= '0;
      buf_q         <= '0;
      newBoard_q    <= '0;
      r_q           <= '0;
      w_q           <= '0;
      done_q        <= 1'b0;
`ifdef ROWCHECK_COUNT_EN
      count_q       <= '0;
      rowsCleared_q <= '0;
`endif
    end else begin
      state_q       <= state_d;
      work_q        <= work_d;
      buf_q         <= buf_d;
      newBoard_q    <= newBoard_d;
      r_q           <= r_d;
      w_q           <= w_d;
      done_q        <= done_d;
`ifdef ROWCHECK_COUNT_EN
      count_q       <= count_d;
      rowsCleared_q <= rowsCleared_d;
`endif
    end
  end

  // The work register shifts down one row per SCAN cycle, so the row under test is always bits [9:0].
  always_comb begin
    state_d       = state_q;
    work_d        = work_q;
    buf_d         = buf_q;
    newBoard_d    = newBoard_q;
    r_d           = r_q;
    w_d           = w_q;
    done_d        = done_q;
    rowVal        = work_q[9:0];
`ifdef ROWCHECK_COUNT_EN
    count_d       = count_q;
    rowsCleared_d = rowsCleared_q;
`endif

    case (state_q)
      LOAD: begin
        work_d  = game_board;
        buf_d   = '0;
        r_d     = '0;
        w_d     = '0;
`ifdef ROWCHECK_COUNT_EN
        count_d = '0;
`endif
        state_d = SCAN;
      end

      SCAN: begin
        if (rowVal != FULL_ROW) begin
          for (int i = 0; i < 20; i++) begin
            if (w_q == 5'(i)) buf_d[i*10 +: 10] = rowVal;
          end
          w_d = w_q + 5'd1;
        end else begin
`ifdef ROWCHECK_COUNT_EN
          count_d = count_q + 5'd1;
`endif
        end
        work_d = {10'd0, work_q[199:10]};
        r_d    = r_q + 5'd1;
        // Outputs are published together on the edge that processes row 19.
        if (r_q == 5'd19) begin
          state_d       = DONE;
          done_d        = 1'b1;
          newBoard_d    = buf_d;
`ifdef ROWCHECK_COUNT_EN
          rowsCleared_d = count_d;
`endif
        end
      end

      DONE: begin
        state_d = DONE;
      end

      default: state_d = LOAD;
    endcase
  end

  assign new_board = newBoard_q;
  assign done      = done_q;
`ifdef ROWCHECK_COUNT_EN
  assign rows_cleared = rowsCleared_q;
`endif

endmodule

// File: tb/tb_row_checker.sv
// Directed self-checking bench for row_checker; checks rows_cleared too when ROWCHECK_COUNT_EN is defined.
module tb_row_checker;

  logic         Clk;
  logic         Reset;
  logic [199:0] game_board;
  logic [199:0] new_board;
  logic         done;
`ifdef ROWCHECK_COUNT_EN
  logic [4:0]   rows_cleared;
`endif

  int checks;
  int errors;

  row_checker dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .game_board (game_board),
    .new_board  (new_board),
`ifdef ROWCHECK_COUNT_EN
    .rows_cleared (rows_cleared),
`endif
    .done       (done)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Asserts reset, loads the board and releases reset away from the rising edge.
  task automatic startCheck(input logic [199:0] board);
    @(negedge Clk);
    Reset      = 1'b1;
    game_board = board;
    @(negedge Clk);
    Reset = 1'b0;
  endtask

  // Runs 20 edges (done must stay low), then the 21st edge, leaving the bench 1 time unit after it.
  task automatic runToDone(input string name);
    repeat (20) @(posedge Clk);
    #1;
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL %s_early_done: got %b expected 0", name, done);
    end
    checks++;
    if (new_board !== 200'd0) begin
      errors++;
      $display("[TB] FAIL %s_early_board: got %h expected 0", name, new_board);
    end
    @(posedge Clk);
    #1;
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("[TB] FAIL %s_done: got %b expected 1", name, done);
    end
  endtask

  task automatic test_reset();
    Reset      = 1'b1;
    game_board = '1;
    #12;
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_done: got %b expected 0", done);
    end
    checks++;
    if (new_board !== 200'd0) begin
      errors++;
      $display("[TB] FAIL reset_board: got %h expected 0", new_board);
    end
`ifdef ROWCHECK_COUNT_EN
    checks++;
    if (rows_cleared !== 5'd0) begin
      errors++;
      $display("[TB] FAIL reset_count: got %0d expected 0", rows_cleared);
    end
`endif
  endtask

  task automatic test_basic();
    logic [199:0] board;
    logic [199:0] expected;
    board        = '0;
    board[9:0]   = 10'h3FF;
    board[19:10] = 10'b0100110010;
    expected     = {190'd0, 10'b0100110010};
    startCheck(board);
    @(posedge Clk);
    #1;
    game_board = '1;
    repeat (19) @(posedge Clk);
    #1;
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL basic_early_done: got %b expected 0", done);
    end
    @(posedge Clk);
    #1;
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("[TB] FAIL basic_done: got %b expected 1", done);
    end
    checks++;
    if (new_board !== expected) begin
      errors++;
      $display("[TB] FAIL basic_board: got %h expected %h", new_board, expected);
    end
`ifdef ROWCHECK_COUNT_EN
    checks++;
    if (rows_cleared !== 5'd1) begin
      errors++;
      $display("[TB] FAIL basic_count: got %0d expected 1", rows_cleared);
    end
`endif
    repeat (5) @(posedge Clk);
    #1;
    checks++;
    if (done !== 1'b1 || new_board !== expected) begin
      errors++;
      $display("[TB] FAIL basic_hold: got done=%b board=%h expected done=1 board=%h", done, new_board, expected);
    end
  endtask

  task automatic test_repulse();
    logic [199:0] board;
    logic [199:0] expected;
    board        = '0;
    board[9:0]   = 10'h3FF;
    board[19:10] = 10'b0100110010;
    expected     = {190'd0, 10'b0100110010};
    @(negedge Clk);
    game_board = board;
    Reset      = 1'b1;
    #1;
    checks++;
    if (done !== 1'b0 || new_board !== 200'd0) begin
      errors++;
      $display("[TB] FAIL repulse_clear: got done=%b board=%h expected done=0 board=0", done, new_board);
    end
    @(negedge Clk);
    Reset = 1'b0;
    runToDone("repulse");
    checks++;
    if (new_board !== expected) begin
      errors++;
      $display("[TB] FAIL repulse_board: got %h expected %h", new_board, expected);
    end
  endtask

  task automatic test_mixed();
    logic [199:0] board;
    logic [199:0] expected;
    board          = '0;
    board[9:0]     = 10'h3FF;
    board[19:10]   = 10'h001;
    board[29:20]   = 10'h3FF;
    board[39:30]   = 10'h002;
    board[49:40]   = 10'h004;
    board[59:50]   = 10'h3FF;
    board[69:60]   = 10'h008;
    expected       = '0;
    expected[9:0]  = 10'h001;
    expected[19:10] = 10'h002;
    expected[29:20] = 10'h004;
    expected[39:30] = 10'h008;
    startCheck(board);
    runToDone("mixed");
    checks++;
    if (new_board !== expected) begin
      errors++;
      $display("[TB] FAIL mixed_board: got %h expected %h", new_board, expected);
    end
`ifdef ROWCHECK_COUNT_EN
    checks++;
    if (rows_cleared !== 5'd3) begin
      errors++;
      $display("[TB] FAIL mixed_count: got %0d expected 3", rows_cleared);
    end
`endif
  endtask

  task automatic test_all_full();
    startCheck('1);
    runToDone("allfull");
    checks++;
    if (new_board !== 200'd0) begin
      errors++;
      $display("[TB] FAIL allfull_board: got %h expected 0", new_board);
    end
`ifdef ROWCHECK_COUNT_EN
    checks++;
    if (rows_cleared !== 5'd20) begin
      errors++;
      $display("[TB] FAIL allfull_count: got %0d expected 20", rows_cleared);
    end
`endif
  endtask

  task automatic test_no_full();
    logic [199:0] board;
    board          = '0;
    board[199:190] = 10'h155;
    board[9:0]     = 10'h2AA;
    board[99:90]   = 10'h3FE;
    startCheck(board);
    runToDone("nofull");
    checks++;
    if (new_board !== board) begin
      errors++;
      $display("[TB] FAIL nofull_board: got %h expected %h", new_board, board);
    end
`ifdef ROWCHECK_COUNT_EN
    checks++;
    if (rows_cleared !== 5'd0) begin
      errors++;
      $display("[TB] FAIL nofull_count: got %0d expected 0", rows_cleared);
    end
`endif
  endtask

  task automatic test_row19_full();
    logic [199:0] board;
    logic [199:0] expected;
    board          = '0;
    board[199:190] = 10'h3FF;
    board[189:180] = 10'h155;
    board[9:0]     = 10'h2AA;
    expected          = board;
    expected[199:190] = 10'h000;
    startCheck(board);
    runToDone("row19");
    checks++;
    if (new_board !== expected) begin
      errors++;
      $display("[TB] FAIL row19_board: got %h expected %h", new_board, expected);
    end
  endtask

  task automatic test_mid_reset();
    logic [199:0] boardA;
    logic [199:0] boardB;
    logic [199:0] expected;
    boardA          = '1;
    boardB          = '0;
    boardB[9:0]     = 10'h3FF;
    boardB[19:10]   = 10'h3FF;
    boardB[29:20]   = 10'h0F0;
    boardB[199:190] = 10'h00F;
    expected          = '0;
    expected[9:0]     = 10'h0F0;
    expected[179:170] = 10'h00F;
    startCheck(boardA);
    repeat (11) @(posedge Clk);
    @(negedge Clk);
    game_board = boardB;
    Reset      = 1'b1;
    #1;
    checks++;
    if (done !== 1'b0 || new_board !== 200'd0) begin
      errors++;
      $display("[TB] FAIL midreset_clear: got done=%b board=%h expected done=0 board=0", done, new_board);
    end
    @(negedge Clk);
    Reset = 1'b0;
    runToDone("midreset");
    checks++;
    if (new_board !== expected) begin
      errors++;
      $display("[TB] FAIL midreset_board: got %h expected %h", new_board, expected);
    end
`ifdef ROWCHECK_COUNT_EN
    checks++;
    if (rows_cleared !== 5'd2) begin
      errors++;
      $display("[TB] FAIL midreset_count: got %0d expected 2", rows_cleared);
    end
`endif
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_basic();
    test_repulse();
    test_mixed();
    test_all_full();
    test_no_full();
    test_row19_full();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
